serial_subtractor: RTL and testbench

- Bit-serial two's-complement subtractor: computes A − B one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
- The subtract-direction counterpart of the team's full-adder cell.
- Used where area matters more than latency, e.g. in sequential datapaths, and as a building block for later serial divide units.
- Parallel operands are loaded with a start/busy/done handshake; the parallel result is presented on completion.

---
 rtl/serial_subtractor.sv | 162 ++++++++++++++++
 tb/tb_serial_subtractor.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial two's-complement subtractor. It computes a - b one bit per clock,
// LSB first, using a single full-subtractor cell and a borrow flip-flop.
// Operands are loaded with a start/busy/done handshake, and the parallel
// result is presented when the operation completes.
//
// Parameters:
//   WIDTH       operand/result width in bits (>= 2)
//
// Ports:
//   clk         system clock, rising-edge active
//   rst         asynchronous active-high reset
//   start       request a new operation (accepted in IDLE or DONE)
//   a           minuend, captured on the accepting edge
//   b           subtrahend, captured on the accepting edge
//   diff        result register, a - b mod 2^WIDTH
//   borrow_out  final borrow, 1 iff unsigned a < b
//   busy        operation in progress
//   done        one-cycle pulse after the result register updates
//   ovf         signed overflow flag (only when SERIAL_SUBTRACTOR_OVF_EN is defined)
//
// Optional feature macro: SERIAL_SUBTRACTOR_OVF_EN
// ---------------------------------------------------------------------------
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             busy,
   output logic             done
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   ,
   output logic             ovf
`endif
);

   // One extra counter bit so the count never wraps before WIDTH bits are done.
   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   state_t           state_next;
   logic             accept;
   logic             last;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] r_sr;
   logic [WIDTH-1:0] r_next;
   logic [CNT_W-1:0] cnt;
   logic             bin;
   logic             ai;
   logic             bi;
   logic             d;
   logic             bout;

   // Full-subtractor cell on the current LSBs.
   assign ai     = a_sr[0];
   assign bi     = b_sr[0];
   assign d      = ai ^ bi ^ bin;
   assign bout   = (~ai & bi) | (~(ai ^ bi) & bin);
   assign r_next = {d, r_sr[WIDTH-1:1]};

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      accept     = 1'b0;
      last       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (cnt == LAST_BIT) begin
               last       = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               accept     = 1'b1;
               state_next = SHIFT;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
   // Operand sign bits are shifted out of the operand registers, so keep them.
   logic a_msb;
   logic b_msb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         ovf   <= 1'b0;
      end else if (accept) begin
         a_msb <= a[WIDTH-1];
         b_msb <= b[WIDTH-1];
      end else if (last) begin
         ovf <= (a_msb ^ b_msb) & (r_next[WIDTH-1] ^ a_msb);
      end
   end
`endif

   // Serial datapath: operand shift, result accumulation, borrow and count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr       <= '0;
         b_sr       <= '0;
         r_sr       <= '0;
         cnt        <= '0;
         bin        <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
      end else if (accept) begin
         a_sr <= a;
         b_sr <= b;
         cnt  <= '0;
         bin  <= 1'b0;
      end else if (state == SHIFT) begin
         a_sr <= a_sr >> 1;
         b_sr <= b_sr >> 1;
         r_sr <= r_next;
         bin  <= bout;
         cnt  <= cnt + CNT_W'(1);
         if (last) begin
            diff       <= r_next;
            borrow_out <= bout;
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//
// Directed testbench for serial_subtractor (WIDTH=8). Stimulus is a linear
// sequence of steps; each comparison is an immediate assertion against a
// hand-computed value. Optional ovf checks follow SERIAL_SUBTRACTOR_OVF_EN.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic [7:0] diff;
   logic       borrow_out;
   logic       busy;
   logic       done;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic       ovf;
`endif

   int total = 0;
   int bad   = 0;
   int n;
   int pulses;

   serial_subtractor #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .a          (a),
      .b          (b),
      .diff       (diff),
      .borrow_out (borrow_out),
      .busy       (busy),
      .done       (done)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ,
      .ovf        (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance edge by edge until done is seen or the budget runs out.
   task automatic wait_done(inout int cnt);
      while (done !== 1'b1 && cnt < 20) begin
         @(posedge clk);
         #1;
         cnt++;
      end
   endtask

   // Full operation from IDLE/DONE: accept, check latency, result and flags.
   task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                         input logic [7:0] ed, input logic eb, input logic eo);
      logic [7:0] prev;
      int         cnt;
      prev  = diff;
      a     = ta;
      b     = tb;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = 8'hAA;
      b     = 8'h55;
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_hold"}, 32'(diff), 32'(prev));
      cnt = 0;
      wait_done(cnt);
      chk({tag, "_lat"}, 32'(cnt), 32'd8);
      chk({tag, "_diff"}, 32'(diff), 32'(ed));
      chk({tag, "_bo"}, 32'(borrow_out), 32'(eb));
      chk({tag, "_nbusy"}, 32'(busy), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
      if (eo === 1'bx) $display("note: unknown ovf expectation for %s", tag);
`endif
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      a     = 8'h00;
      b     = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_bo", 32'(borrow_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      chk("rst_ovf", 32'(ovf), 32'd0);
`endif
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Basic vectors.
      run_op("v5a_23", 8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
      run_op("v10_20", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
      run_op("v00_01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
      run_op("vff_ff", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk("idle_done", 32'(done), 32'd0);

      // Start during SHIFT is ignored; start held in DONE chains an operation.
      a     = 8'h40;
      b     = 8'h01;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n     = 0;
      repeat (2) begin
         @(posedge clk);
         #1;
         n++;
      end
      a     = 8'h00;
      b     = 8'h00;
      start = 1'b1;
      @(posedge clk);
      #1;
      n++;
      start = 1'b0;
      chk("ign_busy", 32'(busy), 32'd1);
      wait_done(n);
      chk("ign_lat", 32'(n), 32'd8);
      chk("ign_diff", 32'(diff), 32'h3F);
      chk("ign_bo", 32'(borrow_out), 32'd0);
      a     = 8'h09;
      b     = 8'h04;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("b2b_busy", 32'(busy), 32'd1);
      chk("b2b_done", 32'(done), 32'd0);
      n = 0;
      wait_done(n);
      chk("b2b_lat", 32'(n), 32'd8);
      chk("b2b_diff", 32'(diff), 32'h05);

      // Asynchronous reset in the middle of an operation.
      run_op("pre_rst", 8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
      a     = 8'h10;
      b     = 8'h20;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_diff", 32'(diff), 32'd0);
      chk("arst_bo", 32'(borrow_out), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      pulses = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) pulses++;
      end
      chk("arst_nodone", 32'(pulses), 32'd0);
      run_op("post_rst", 8'h03, 8'h01, 8'h02, 1'b0, 1'b0);

      // Signed overflow vectors (ovf checked when the feature is built in).
      run_op("ov80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
      run_op("ov7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
      run_op("ov05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
